// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit_pkg
//  Purpose  : Shared definitions for the branch resolve unit: chooser
//             encodings, the delay-slot redirect offset and the metadata
//             records carried through the D->E and E->M pipeline registers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_unit_pkg;

  // 2-bit saturating chooser states; MSB = 1 selects the global component.
  localparam logic [1:0] c_chooser_strong_local  = 2'b00;
  localparam logic [1:0] c_chooser_weak_local    = 2'b01;
  localparam logic [1:0] c_chooser_weak_global   = 2'b10;
  localparam logic [1:0] c_chooser_strong_global = 2'b11;

  // Fall-through fetch address skips the branch and its delay slot.
  localparam logic [31:0] c_delay_slot_offset = 32'd8;

  // Metadata held in the D->E register.
  typedef struct packed {
    logic        branch;
    logic [31:0] pc;
    logic        pred_global;
    logic        pred_local;
    logic        pred_choose;
  } de_meta_t;

  // Resolved branch record held in the E->M register.
  typedef struct packed {
    logic        branch;
    logic [31:0] pc;
    logic        actual_taken;
    logic        global_error;
    logic        local_error;
    logic        mispred;
    logic [31:0] redirect_pc;
  } em_meta_t;

  // Chooser state -> "use global" bit.
  function automatic logic chooser_selects_global(input logic [1:0] state);
    return (state == c_chooser_strong_global) || (state == c_chooser_weak_global);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_pipe_reg
//  Purpose  : Generic pipeline register with flush (clear) and stall (hold).
//             Flush has priority over stall; reset is asynchronous.
//  Ports    : clk, rst           - clock, async active-high reset
//             i_flush, i_stall   - clear / hold controls
//             i_d, o_q           - WIDTH-bit data in / registered out
//  Revision : 1.0 - initial release
// ============================================================================
module branch_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q <= '0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Carries tournament-predictor metadata from D to E, resolves the
//             branch in E (per-component errors, final misprediction and the
//             correct fetch PC) and presents the result registered in M along
//             with a one-shot predictor update strobe.
//  Config   : BRANCH_PERF_CNT_EN - when defined, saturating branch and
//             misprediction counters are built; otherwise both read as 0.
//  Ports    : clk, rst                      - clock, async active-high reset
//             branchD, pcD, pred_*D         - D-stage branch and predictions
//             stallE/flushE, stallM/flushM  - pipeline hold / kill controls
//             actual_takenE, branch_targetE - E-stage resolution
//             branchM, pcM, actual_takenM   - M-stage branch record
//             global_errorM, local_errorM   - per-component mispredictions
//             mispredM, redirect_pcM        - final misprediction, fetch PC
//             branch_updateM                - predictor update strobe
//             perf_branches, perf_mispred   - performance counters
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branchD,
  input  logic [31:0]          pcD,
  input  logic                 pred_globalD,
  input  logic                 pred_localD,
  input  logic                 pred_chooseD,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 stallM,
  input  logic                 flushM,
  input  logic                 actual_takenE,
  input  logic [31:0]          branch_targetE,
  output logic                 branchM,
  output logic                 actual_takenM,
  output logic [31:0]          pcM,
  output logic                 global_errorM,
  output logic                 local_errorM,
  output logic                 mispredM,
  output logic [31:0]          redirect_pcM,
  output logic                 branch_updateM,
  output logic [CNT_WIDTH-1:0] perf_branches,
  output logic [CNT_WIDTH-1:0] perf_mispred
);

  de_meta_t w_de_d;
  de_meta_t w_de_q;
  em_meta_t w_em_d;
  em_meta_t w_em_q;
  logic     w_final_predE;

  // ---------------- D -> E ----------------
  assign w_de_d.branch      = branchD;
  assign w_de_d.pc          = pcD;
  assign w_de_d.pred_global = pred_globalD;
  assign w_de_d.pred_local  = pred_localD;
  assign w_de_d.pred_choose = pred_chooseD;

  branch_pipe_reg #(
    .WIDTH ($bits(de_meta_t))
  ) u_de_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flushE),
    .i_stall (stallE),
    .i_d     (w_de_d),
    .o_q     (w_de_q)
  );

  // ---------------- E-stage resolution ----------------
  assign w_final_predE = w_de_q.pred_choose ? w_de_q.pred_global : w_de_q.pred_local;

  assign w_em_d.branch       = w_de_q.branch;
  assign w_em_d.pc           = w_de_q.pc;
  assign w_em_d.actual_taken = actual_takenE;
  assign w_em_d.global_error = w_de_q.branch & (w_de_q.pred_global != actual_takenE);
  assign w_em_d.local_error  = w_de_q.branch & (w_de_q.pred_local  != actual_takenE);
  assign w_em_d.mispred      = w_de_q.branch & (w_final_predE      != actual_takenE);
  // Not-taken resumes after the delay slot; 32-bit add wraps naturally.
  assign w_em_d.redirect_pc  = actual_takenE ? branch_targetE
                                             : (w_de_q.pc + c_delay_slot_offset);

  // ---------------- E -> M ----------------
  branch_pipe_reg #(
    .WIDTH ($bits(em_meta_t))
  ) u_em_reg (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flushM),
    .i_stall (stallM),
    .i_d     (w_em_d),
    .o_q     (w_em_q)
  );

  assign branchM       = w_em_q.branch;
  assign pcM           = w_em_q.pc;
  assign actual_takenM = w_em_q.actual_taken;
  assign global_errorM = w_em_q.global_error;
  assign local_errorM  = w_em_q.local_error;
  assign mispredM      = w_em_q.mispred;
  assign redirect_pcM  = w_em_q.redirect_pc;

  // Fires on the cycle the branch leaves M, so a stalled branch strobes once.
  assign branch_updateM = w_em_q.branch & ~stallM;

  // ---------------- performance counters ----------------
`ifdef BRANCH_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_perf_branches;
  logic [CNT_WIDTH-1:0] r_perf_mispred;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else if (branch_updateM) begin
      if (r_perf_branches != '1) begin
        r_perf_branches <= r_perf_branches + c_cnt_one;
      end
      if (mispredM && (r_perf_mispred != '1)) begin
        r_perf_mispred <= r_perf_mispred + c_cnt_one;
      end
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_mispred  = r_perf_mispred;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Purpose  : Self-checking bench for branch_resolve_unit: directed cases with
//             literal expectations followed by randomized traffic compared
//             every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              branchD = 1'b0;
  logic [31:0]       pcD = '0;
  logic              pred_globalD = 1'b0, pred_localD = 1'b0, pred_chooseD = 1'b0;
  logic              stallE = 1'b0, flushE = 1'b0, stallM = 1'b0, flushM = 1'b0;
  logic              actual_takenE = 1'b0;
  logic [31:0]       branch_targetE = '0;
  logic              branchM, actual_takenM, global_errorM, local_errorM, mispredM;
  logic [31:0]       pcM, redirect_pcM;
  logic              branch_updateM;
  logic [CNT_W-1:0]  perf_branches, perf_mispred;

  branch_resolve_unit #(.CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .branchD(branchD), .pcD(pcD),
    .pred_globalD(pred_globalD), .pred_localD(pred_localD), .pred_chooseD(pred_chooseD),
    .stallE(stallE), .flushE(flushE), .stallM(stallM), .flushM(flushM),
    .actual_takenE(actual_takenE), .branch_targetE(branch_targetE),
    .branchM(branchM), .actual_takenM(actual_takenM), .pcM(pcM),
    .global_errorM(global_errorM), .local_errorM(local_errorM), .mispredM(mispredM),
    .redirect_pcM(redirect_pcM), .branch_updateM(branch_updateM),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        br;
    logic [31:0] pc;
    logic        g, l, c;
  } e_slot_t;

  typedef struct packed {
    logic        br;
    logic [31:0] pc;
    logic        taken;
    logic        gerr, lerr, mis;
    logic [31:0] redir;
  } m_slot_t;

  e_slot_t me = '0;
  m_slot_t mm = '0;
  int      exp_pb = 0;
  int      exp_pm = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      me = '0; mm = '0; exp_pb = 0; exp_pm = 0;
    end else begin
`ifdef BRANCH_PERF_CNT_EN
      if (mm.br && !stallM) begin
        if (exp_pb < CNT_MAX) exp_pb++;
        if (mm.mis && exp_pm < CNT_MAX) exp_pm++;
      end
`endif
      if (flushM) mm = '0;
      else if (!stallM) begin
        mm.br    = me.br;
        mm.pc    = me.pc;
        mm.taken = actual_takenE;
        mm.gerr  = me.br && (me.g != actual_takenE);
        mm.lerr  = me.br && (me.l != actual_takenE);
        mm.mis   = me.br && ((me.c ? me.g : me.l) != actual_takenE);
        mm.redir = actual_takenE ? branch_targetE : me.pc + 32'd8;
      end
      if (flushE) me = '0;
      else if (!stallE) me = '{branchD, pcD, pred_globalD, pred_localD, pred_chooseD};
    end
  end

  // Every-cycle comparison, after inputs for the coming edge are applied.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("branchM", branchM, mm.br);
      chk("pcM", pcM, mm.pc);
      chk("actual_takenM", actual_takenM, mm.taken);
      chk("global_errorM", global_errorM, mm.gerr);
      chk("local_errorM", local_errorM, mm.lerr);
      chk("mispredM", mispredM, mm.mis);
      chk("redirect_pcM", redirect_pcM, mm.redir);
      chk("branch_updateM", branch_updateM, mm.br && !stallM && !rst);
      chk("perf_branches", perf_branches, exp_pb);
      chk("perf_mispred", perf_mispred, exp_pm);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    branchD = 0; pcD = '0; pred_globalD = 0; pred_localD = 0; pred_chooseD = 0;
    stallE = 0; flushE = 0; stallM = 0; flushM = 0; actual_takenE = 0; branch_targetE = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic g, input logic l, input logic c);
    branchD = 1; pcD = pc; pred_globalD = g; pred_localD = l; pred_chooseD = c;
  endtask

  initial begin
    idle();
    repeat (3) step();
    #2;
    chk("reset branchM", branchM, 1'b0);
    chk("reset redirect_pcM", redirect_pcM, 32'h0);
    chk("reset branch_updateM", branch_updateM, 1'b0);
    step(); rst = 0;

    // Global-chosen, predicted taken, actually not taken.
    step(); issue(32'h0040_0010, 1, 0, 1);
    step(); branchD = 0; actual_takenE = 0;
    step(); actual_takenE = 0; #2;
    chk("t35 branchM", branchM, 1'b1);
    chk("t35 global_errorM", global_errorM, 1'b1);
    chk("t35 local_errorM", local_errorM, 1'b0);
    chk("t35 mispredM", mispredM, 1'b1);
    chk("t35 redirect_pcM", redirect_pcM, 32'h0040_0018);

    // Local-chosen, predicted not taken, actually taken.
    step(); issue(32'h0040_0010, 1, 0, 0);
    step(); branchD = 0; actual_takenE = 1; branch_targetE = 32'h0040_0100;
    step(); actual_takenE = 0; branch_targetE = '0; #2;
    chk("t36 global_errorM", global_errorM, 1'b0);
    chk("t36 local_errorM", local_errorM, 1'b1);
    chk("t36 mispredM", mispredM, 1'b1);
    chk("t36 redirect_pcM", redirect_pcM, 32'h0040_0100);

    // Branch held in M for three cycles: one strobe on release.
    step(); issue(32'h0000_1000, 0, 0, 0);
    step(); branchD = 0;
    step(); stallM = 1; #2;
    chk("t37 branchM held", branchM, 1'b1);
    chk("t37 stall1 upd", branch_updateM, 1'b0);
    step(); #2;
    chk("t37 stall2 upd", branch_updateM, 1'b0);
    chk("t37 pcM held", pcM, 32'h0000_1000);
    step(); #2;
    chk("t37 stall3 upd", branch_updateM, 1'b0);
    step(); stallM = 0; #2;
    chk("t37 release upd", branch_updateM, 1'b1);
    step(); #2;
    chk("t37 after upd", branch_updateM, 1'b0);

    // flushM on the capture cycle kills the branch.
    step(); issue(32'h0000_2000, 1, 1, 1);
    step(); branchD = 0; flushM = 1;
    step(); flushM = 0; #2;
    chk("t38 branchM", branchM, 1'b0);
    chk("t38 global_errorM", global_errorM, 1'b0);
    chk("t38 mispredM", mispredM, 1'b0);
    chk("t38 upd", branch_updateM, 1'b0);

    // Asynchronous reset with branches in E and M.
    step(); issue(32'h0000_3000, 1, 1, 1);
    step(); issue(32'h0000_3010, 0, 0, 0); actual_takenE = 0;
    step(); branchD = 0; actual_takenE = 1;
    #3; rst = 1; #1;
    chk("t39 branchM", branchM, 1'b0);
    chk("t39 pcM", pcM, 32'h0);
    chk("t39 redirect_pcM", redirect_pcM, 32'h0);
    chk("t39 upd", branch_updateM, 1'b0);
    step(); step(); rst = 0; actual_takenE = 0;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("t39 no strobe", branch_updateM, 1'b0);
    end

    // 17 mispredicted branches saturate 4-bit counters.
    for (int i = 0; i < 17; i++) begin
      step(); issue(32'h0000_4000 + 32'(i * 4), 1, 1, 1); actual_takenE = 0;
    end
    step(); branchD = 0;
    repeat (3) step();
    #2;
`ifdef BRANCH_PERF_CNT_EN
    chk("t40 perf_branches", perf_branches, 4'd15);
    chk("t40 perf_mispred", perf_mispred, 4'd15);
`else
    chk("t40 perf_branches off", perf_branches, 4'd0);
    chk("t40 perf_mispred off", perf_mispred, 4'd0);
`endif

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      step();
      branchD        = 1'($urandom_range(0, 1));
      pcD            = $urandom;
      pred_globalD   = 1'($urandom_range(0, 1));
      pred_localD    = 1'($urandom_range(0, 1));
      pred_chooseD   = 1'($urandom_range(0, 1));
      stallE         = ($urandom_range(0, 7) == 0);
      flushE         = ($urandom_range(0, 9) == 0);
      stallM         = ($urandom_range(0, 5) == 0);
      flushM         = ($urandom_range(0, 9) == 0);
      actual_takenE  = 1'($urandom_range(0, 1));
      branch_targetE = (i % 97 == 0) ? 32'hFFFF_FFFC : $urandom;
      if (i % 500 == 250) begin
        #3; rst = 1; #4; rst = 0;
      end
    end
    step(); idle();
    repeat (3) step();
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter CNT_WIDTH, 32, width of each performance counter.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 branchD  in  1  instruction in D is a conditional branch.
REQ-005 pcD  in  32  PC of the D-stage instruction.
REQ-006 pred_globalD, pred_localD, pred_chooseD  in  1 each  global prediction, local prediction, chooser bit (1 = use global).
REQ-007 stallE, flushE, stallM, flushM  in  1 each  pipeline hold and kill controls for the E and M registers.
REQ-008 actual_takenE  in  1  resolved branch direction in E.
REQ-009 branch_targetE  in  32  resolved taken target in E.
REQ-010 branchM, actual_takenM  out  1 each  branch present in M; its resolved direction.
REQ-011 pcM  out  32  PC of the M-stage branch.
REQ-012 global_errorM, local_errorM  out  1 each  global or local component mispredicted the M-stage branch.
REQ-013 mispredM  out  1  final (chosen) prediction was wrong.
REQ-014 redirect_pcM  out  32  correct fetch PC after a misprediction.
REQ-015 branch_updateM  out  1  one-cycle predictor-table update strobe.
REQ-016 perf_branches, perf_mispred  out  CNT_WIDTH each  performance counters (see REQ-032).

Function
REQ-017 D->E register captures branchD, pcD, pred_globalD, pred_localD, pred_chooseD; when flushE=1 it clears, else when stallE=0 it loads, else it holds; flush has priority over stall.
REQ-018 finalE = pred_chooseE ? pred_globalE : pred_localE.
REQ-019 E stage computes: gerrE = branchE & (pred_globalE != actual_takenE); lerrE = branchE & (pred_localE != actual_takenE); misE = branchE & (finalE != actual_takenE).
REQ-020 Redirect target: actual_takenE ? branch_targetE : pcE + 8 (delay slot skipped), 32-bit wrap-around on addition.
REQ-021 E->M register captures branchE, pcE, actual_takenE, gerrE, lerrE, misE and the redirect target; flushM clears it, stallM=0 loads it, else holds; flushM has priority.
REQ-022 Outputs in REQ-010..REQ-014 are driven directly from the E->M register; latency D to M is exactly two unstalled cycles.
REQ-023 branch_updateM = branchM & ~stallM (combinational), so a branch held in M by stalls produces exactly one update strobe.
REQ-024 A cleared pipeline slot carries branch=0 and all error flags 0; errors never assert without branchM.
REQ-025 mispredM=1 implies global_errorM=1 when chooser selected global, local_errorM=1 otherwise.
REQ-026 When both components are right or both wrong, both error flags reflect that exactly; chooser training policy belongs to the chooser.
REQ-027 Simultaneous flushE and stallM: E register clears while M holds; no interaction.

Reset
REQ-028 rst asynchronously clears both pipeline registers: branchM, actual_takenM, global_errorM, local_errorM, mispredM = 0; pcM, redirect_pcM = 32'h0.
REQ-029 branch_updateM = 0 during and immediately after reset until a branch reaches M.
REQ-030 Reset mid-operation discards all in-flight branches; no update strobe is produced for them.
REQ-031 perf counters reset to 0 when REQ-032 macro is defined.

Configuration
REQ-032 Macro BRANCH_PERF_CNT_EN: defined -> perf_branches increments on each branch_updateM, perf_mispred increments on each branch_updateM with mispredM=1, both saturate at all-ones; undefined -> both outputs tied to 0, no counter flops.

Structure
REQ-033 Shared package holds: chooser encoding constants (strongly/weakly global/local), delay-slot redirect offset (8), the E/M metadata record typedef.
REQ-034 One sub-module natural: branch_pipe_reg, a parameterised flush/stall pipeline register instanced for D->E and E->M.

Verification
REQ-035 Branch pcD=0x00400010, global=1, local=0, choose=1, actual=0 -> two cycles later branchM=1, global_errorM=1, local_errorM=0, mispredM=1, redirect_pcM=0x00400018.
REQ-036 Same but actual=1, branch_targetE=0x00400100, choose=0 -> global_errorM=0, local_errorM=1, mispredM=1, redirect_pcM=0x00400100.
REQ-037 Branch in M with stallM=1 for 3 cycles -> outputs held, branch_updateM=0 for 3 cycles then 1 for exactly one cycle.
REQ-038 Branch in E with flushM=1 on capture cycle -> branchM=0, all error flags 0, no strobe.
REQ-039 rst pulsed while branch in E -> all outputs 0 asynchronously, no later strobe.
REQ-040 BRANCH_PERF_CNT_EN, CNT_WIDTH=4, 17 mispredicted branches -> both counters saturate at 15.
